// File: rtl/kmeans_centroid_update_pkg.sv
// Shared types and constants for the K-means mean-update slice.
// Channel order within a pixel is {R,G,B}, R in the top byte.
package kmeans_pkg;

  localparam int PIX_W     = 24;
  localparam int CH_W      = 8;
  localparam int K_DEFAULT = 4;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Replace one channel of a mean, leaving the other two intact.
  function automatic rgb_t set_ch(
    rgb_t            v,
    logic [1:0]      c,
    logic [CH_W-1:0] q
  );
    rgb_t o;
    o = v;
    case (c)
      CH_R:    o.r = q;
      CH_G:    o.g = q;
      default: o.b = q;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/kmeans_centroid_update_if.sv
// Pixel/assignment stream from the argmin stage into the mean updater.
// The master drives pixels, the slave (updater) drives pix_ready.
interface kmeans_centroid_update_if
  import kmeans_pkg::*;
#(
  parameter int K = K_DEFAULT
);
  localparam int IW = $clog2(K);

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pixel;
  logic [IW-1:0]    cluster_idx;
  logic             frame_end;

  modport master (
    output pix_valid,
    output pixel,
    output cluster_idx,
    output frame_end,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pixel,
    input  cluster_idx,
    input  frame_end,
    output pix_ready
  );

endinterface

// File: rtl/kmeans_centroid_update_div.sv
// Serial restoring divider, 8-bit quotient, fixed 9-cycle run.
// done/quotient are valid in the 9th cycle (last iteration).
module kmeans_div_u8
  import kmeans_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_W+CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0]      divisor,
  output logic [CH_W-1:0]       quotient,
  output logic                  done
);
  localparam int SW = CH_W + CNT_W;

  logic [SW-1:0]   rem;
  logic [SW-1:0]   dsh;
  logic [CH_W-1:0] quo;
  logic [2:0]      step;
  logic            run;
  logic            ge;

  assign dsh      = SW'(divisor) << (3'd7 - step);
  assign ge       = rem >= dsh;
  assign done     = run && (step == 3'd7);
  assign quotient = {quo[CH_W-2:0], ge};

  // Load on start, then one quotient bit per cycle, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      step <= '0;
      run  <= 1'b0;
    end else if (start) begin
      rem  <= dividend;
      quo  <= '0;
      step <= '0;
      run  <= 1'b1;
    end else if (run) begin
      if (ge) rem <= rem - dsh;
      quo  <= {quo[CH_W-2:0], ge};
      step <= step + 3'd1;
      if (step == 3'd7) run <= 1'b0;
    end
  end

endmodule

// File: rtl/kmeans_centroid_update.sv
// K-means mean update: accumulate assigned pixels, divide, commit.
// Optional: define KMEANS_CONVERGE_EN for the converged flag.
module kmeans_centroid_update
  import kmeans_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int CNT_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mean_load,
  input  logic [$clog2(K)-1:0]    load_idx,
  input  logic [PIX_W-1:0]        load_mean,
  input  logic                    start,
  kmeans_centroid_update_if.slave pix,
  output logic [PIX_W*K-1:0]      means_flat,
  output logic                    busy,
  output logic                    update_done,
  output logic                    converged
);
  localparam int IW = $clog2(K);
  localparam int SW = CH_W + CNT_W;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCUM  = ACCUM;
  localparam logic [1:0] S_DIVIDE = DIVIDE;
  localparam logic [1:0] S_COMMIT = COMMIT;

  logic [1:0]       state;
  rgb_t             means  [K];
  rgb_t             shadow [K];
  logic [SW-1:0]    sums   [K][3];
  logic [CNT_W-1:0] cnt    [K];

  logic [IW-1:0]    cl;
  logic [1:0]       ch;
  logic             div_run;

  rgb_t             px;
  logic [IW-1:0]    pidx;
  logic [IW-1:0]    cidx;
  logic             idx_ok;
  logic             load_ok;
  logic             take;
  logic             clr;
  logic             empty;
  logic             div_start;
  logic             div_done;
  logic             ch_done;
  logic             cl_adv;
  logic [CH_W-1:0]  div_q;

  assign px     = pix.pixel;
  assign pidx   = pix.cluster_idx;
  assign idx_ok = int'(pidx) < K;
  assign cidx   = idx_ok ? pidx : '0;

  assign pix.pix_ready = (state == S_ACCUM);
  assign busy          = (state != S_IDLE);

  assign clr  = (state == S_IDLE) && start;
  assign take = pix.pix_valid && pix.pix_ready
             && idx_ok && (cnt[cidx] != '1);

  assign load_ok = int'(load_idx) < K;

  assign empty     = (cnt[cl] == '0);
  assign div_start = (state == S_DIVIDE)
                  && !empty && !div_run;
  assign ch_done   = div_run && div_done;
  assign cl_adv    = (state == S_DIVIDE)
                  && (empty || (ch_done && ch == CH_B));

  kmeans_div_u8 #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sums[cl][ch]),
    .divisor  (cnt[cl]),
    .quotient (div_q),
    .done     (div_done)
  );

  // Pass sequencing and the cluster/channel walk through DIVIDE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cl          <= '0;
      ch          <= '0;
      div_run     <= 1'b0;
      update_done <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (pix.frame_end) begin
            state   <= S_DIVIDE;
            cl      <= '0;
            ch      <= '0;
            div_run <= 1'b0;
          end
        end
        S_DIVIDE: begin
          if (div_start) div_run <= 1'b1;
          if (ch_done) begin
            div_run <= 1'b0;
            ch      <= (ch == CH_B) ? CH_R : ch + 2'd1;
          end
          if (cl_adv) begin
            if (cl == IW'(K - 1)) begin
              cl    <= '0;
              state <= S_COMMIT;
            end else begin
              cl <= cl + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          state       <= S_IDLE;
          update_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-cluster channel sums and saturating-by-drop pixel counts.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < K; k++) begin
        cnt[k] <= '0;
        for (int c = 0; c < 3; c++)
          sums[k][c] <= '0;
      end
    end else if (take) begin
      sums[cidx][0] <= sums[cidx][0] + SW'(px.r);
      sums[cidx][1] <= sums[cidx][1] + SW'(px.g);
      sums[cidx][2] <= sums[cidx][2] + SW'(px.b);
      cnt[cidx]     <= cnt[cidx] + 1'b1;
    end
  end

  // Committed means, and shadow means built up during DIVIDE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        means[k]  <= '0;
        shadow[k] <= '0;
      end
    end else begin
      if (state == S_IDLE && mean_load
          && !start && load_ok)
        means[load_idx] <= load_mean;
      if (state == S_DIVIDE && empty)
        shadow[cl] <= means[cl];
      if (ch_done)
        shadow[cl] <= set_ch(shadow[cl], ch, div_q);
      if (state == S_COMMIT)
        for (int k = 0; k < K; k++)
          means[k] <= shadow[k];
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_flat
    assign means_flat[PIX_W*k +: PIX_W] = means[k];
  end

`ifdef KMEANS_CONVERGE_EN
  logic same;
  logic conv_q;

  // Every new mean identical to the one it replaces.
  always_comb begin
    same = 1'b1;
    for (int k = 0; k < K; k++)
      if (shadow[k] != means[k]) same = 1'b0;
  end

  // Flag is judged at commit and held until the next pass starts.
  always_ff @(posedge clk) begin
    if (rst || clr)
      conv_q <= 1'b0;
    else if (state == S_COMMIT)
      conv_q <= same;
  end

  assign converged = conv_q;
`else
  assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Bench: K=4/CNT_W=20 and K=3/CNT_W=2 instances fed the same stream,
// each compared against a per-cluster sum/count mean model.
module tb_kmeans_centroid_update;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mean_load = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  load_idx = '0;
  logic [23:0] load_mean = '0;

  logic [95:0] mf4;
  logic [71:0] mf3;
  logic        busy4, busy3, ud4, ud3, cv4, cv3;

  kmeans_centroid_update_if #(.K(4)) ifa ();
  kmeans_centroid_update_if #(.K(3)) ifb ();

  kmeans_centroid_update #(.K(4), .CNT_W(20)) dut4 (
    .clk(clk), .rst(rst),
    .mean_load(mean_load), .load_idx(load_idx),
    .load_mean(load_mean), .start(start),
    .pix(ifa.slave), .means_flat(mf4),
    .busy(busy4), .update_done(ud4), .converged(cv4)
  );

  kmeans_centroid_update #(.K(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst),
    .mean_load(mean_load), .load_idx(load_idx),
    .load_mean(load_mean), .start(start),
    .pix(ifb.slave), .means_flat(mf3),
    .busy(busy3), .update_done(ud3), .converged(cv3)
  );

  int          kk   [2] = '{4, 3};
  int          cmax [2] = '{1048575, 3};
  logic [23:0] ms   [2][4];
  int          sm   [2][4][3];
  int          cn   [2][4];
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] get_mf(int d);
    return (d == 0) ? mf4 : {24'd0, mf3};
  endfunction
  function automatic logic get_ud(int d);
    return (d == 0) ? ud4 : ud3;
  endfunction
  function automatic logic get_cv(int d);
    return (d == 0) ? cv4 : cv3;
  endfunction
  function automatic logic get_busy(int d);
    return (d == 0) ? busy4 : busy3;
  endfunction
  function automatic logic get_rdy(int d);
    return (d == 0) ? ifa.pix_ready : ifb.pix_ready;
  endfunction

  function automatic logic [95:0] flat(int d);
    logic [95:0] v;
    v = '0;
    for (int k = 0; k < kk[d]; k++) v[24*k +: 24] = ms[d][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        ms[d][k] = '0;
        cn[d][k] = 0;
        for (int c = 0; c < 3; c++) sm[d][k][c] = 0;
      end
  endtask

  task automatic drive(logic v, logic [23:0] px,
                       logic [1:0] idx, logic fe);
    ifa.pix_valid = v; ifa.pixel = px;
    ifa.cluster_idx = idx; ifa.frame_end = fe;
    ifb.pix_valid = v; ifb.pixel = px;
    ifb.cluster_idx = idx; ifb.frame_end = fe;
  endtask

  task automatic send(logic [23:0] px, logic [1:0] idx, logic fe);
    drive(1'b1, px, idx, fe);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int d = 0; d < 2; d++)
      if (int'(idx) < kk[d] && cn[d][idx] < cmax[d]) begin
        sm[d][idx][0] += int'(px[23:16]);
        sm[d][idx][1] += int'(px[15:8]);
        sm[d][idx][2] += int'(px[7:0]);
        cn[d][idx]++;
      end
  endtask

  task automatic load(logic [1:0] idx, logic [23:0] val);
    mean_load = 1'b1; load_idx = idx; load_mean = val;
    tick();
    mean_load = 1'b0;
    for (int d = 0; d < 2; d++)
      if (int'(idx) < kk[d]) ms[d][idx] = val;
    for (int d = 0; d < 2; d++)
      chk($sformatf("load%0d_d%0d", idx, d), get_mf(d), flat(d));
  endtask

  task automatic begin_pass(logic wl, logic [1:0] li, logic [23:0] lv);
    start = 1'b1; mean_load = wl; load_idx = li; load_mean = lv;
    tick();
    start = 1'b0; mean_load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        cn[d][k] = 0;
        for (int c = 0; c < 3; c++) sm[d][k][c] = 0;
      end
      chk($sformatf("ready_d%0d", d), 96'(get_rdy(d)), 96'd1);
      chk($sformatf("cv_clr_d%0d", d), 96'(get_cv(d)), 96'd0);
    end
  endtask

  task automatic end_pass(logic fe_pix, logic [23:0] px,
                          logic [1:0] idx, logic guard);
    logic [95:0] hold [2];
    int          seen [2];
    int          pulses [2];
    logic        held [2];
    logic        cva [2];
    int          lat;
    logic        same;
    logic        expc;
    logic [23:0] nm;
    if (fe_pix) send(px, idx, 1'b1);
    else begin
      drive(1'b0, '0, '0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
    end
    for (int d = 0; d < 2; d++) begin
      hold[d] = get_mf(d); seen[d] = -1;
      pulses[d] = 0; held[d] = 1'b1; cva[d] = 1'bx;
      chk($sformatf("rdy_off_d%0d", d), 96'(get_rdy(d)), 96'd0);
    end
    for (int t = 1; t <= 130; t++) begin
      if (guard && t == 5) begin
        start = 1'b1; mean_load = 1'b1;
        load_idx = 2'd1; load_mean = 24'($urandom);
      end
      tick();
      start = 1'b0; mean_load = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (get_ud(d)) begin
          pulses[d]++;
          if (seen[d] < 0) begin seen[d] = t; cva[d] = get_cv(d); end
        end
        if (seen[d] < 0 && get_mf(d) !== hold[d]) held[d] = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      lat = 2; same = 1'b1;
      for (int k = 0; k < kk[d]; k++) begin
        if (cn[d][k] == 0) begin
          nm = ms[d][k]; lat += 1;
        end else begin
          nm = {8'(sm[d][k][0] / cn[d][k]), 8'(sm[d][k][1] / cn[d][k]),
                8'(sm[d][k][2] / cn[d][k])};
          lat += 27;
        end
        if (nm != ms[d][k]) same = 1'b0;
        ms[d][k] = nm;
      end
`ifdef KMEANS_CONVERGE_EN
      expc = same;
`else
      expc = 1'b0;
`endif
      chk($sformatf("latency_d%0d", d), 96'(1 + seen[d]), 96'(lat));
      chk($sformatf("pulses_d%0d", d), 96'(pulses[d]), 96'd1);
      chk($sformatf("hold_d%0d", d), 96'(held[d]), 96'd1);
      chk($sformatf("means_d%0d", d), get_mf(d), flat(d));
      chk($sformatf("conv_at_done_d%0d", d), 96'(cva[d]), 96'(expc));
      chk($sformatf("conv_held_d%0d", d), 96'(get_cv(d)), 96'(expc));
      chk($sformatf("idle_d%0d", d), 96'(get_busy(d)), 96'd0);
    end
  endtask

  initial begin
    int          n;
    int          pulses;
    logic [23:0] px;
    drive(1'b0, '0, '0, 1'b0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_means_d%0d", d), get_mf(d), 96'd0);
      chk($sformatf("rst_busy_d%0d", d), 96'(get_busy(d)), 96'd0);
      chk($sformatf("rst_ready_d%0d", d), 96'(get_rdy(d)), 96'd0);
      chk($sformatf("rst_done_d%0d", d), 96'(get_ud(d)), 96'd0);
      chk($sformatf("rst_conv_d%0d", d), 96'(get_cv(d)), 96'd0);
    end

    for (int k = 0; k < 4; k++) load(2'(k), 24'($urandom));
    begin_pass(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) send(24'($urandom), 2'(i), 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_means_d%0d", d), get_mf(d), 96'd0);
      chk($sformatf("abort_busy_d%0d", d), 96'(get_busy(d)), 96'd0);
      chk($sformatf("abort_ready_d%0d", d), 96'(get_rdy(d)), 96'd0);
    end
    drive(1'b0, '0, '0, 1'b1);
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      drive(1'b0, '0, '0, 1'b0);
      pulses += int'(ud4) + int'(ud3);
    end
    chk("abort_no_done", 96'(pulses), 96'd0);

    for (int k = 0; k < 4; k++) load(2'(k), 24'd0);
    begin_pass(1'b0, '0, '0);
    send({8'd10, 8'd20, 8'd30}, 2'd1, 1'b0);
    send({8'd20, 8'd30, 8'd40}, 2'd1, 1'b0);
    send({8'd30, 8'd40, 8'd51}, 2'd1, 1'b0);
    end_pass(1'b0, '0, '0, 1'b1);
    chk("basic_m1", 96'(mf4[47:24]), 96'h141e28);

    load(2'd2, {8'd7, 8'd8, 8'd9});
    begin_pass(1'b1, 2'd2, 24'hffffff);
    for (int i = 0; i < 10; i++)
      send(24'($urandom), (i % 3 == 2) ? 2'd3 : 2'(i % 3), 1'b0);
    end_pass(1'b0, '0, '0, 1'b0);
    chk("empty_d4", 96'(mf4[71:48]), 96'h070809);
    chk("empty_d3", 96'(mf3[71:48]), 96'h070809);

    begin_pass(1'b0, '0, '0);
    send({3{8'd10}}, 2'd0, 1'b0);
    send({3{8'd20}}, 2'd0, 1'b0);
    send({3{8'd30}}, 2'd0, 1'b0);
    send({3{8'd250}}, 2'd0, 1'b0);
    send({3{8'd250}}, 2'd0, 1'b0);
    send(24'($urandom), 2'd3, 1'b0);
    end_pass(1'b1, {3{8'd90}}, 2'd1, 1'b0);
    chk("sat_d3_m0", 96'(mf3[23:0]), 96'h141414);
    chk("fe_pix_d3_m1", 96'(mf3[47:24]), 96'h5a5a5a);

    for (int p = 0; p < 4; p++) begin
      begin_pass(1'b0, '0, '0);
      n = $urandom_range(60, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3) == 0) tick();
        send(24'($urandom), 2'($urandom_range(3)), 1'b0);
      end
      end_pass(1'($urandom_range(1)), 24'($urandom),
               2'($urandom_range(3)), p == 1);
    end

    for (int k = 0; k < 4; k++) load(2'(k), 24'($urandom));
    begin_pass(1'b0, '0, '0);
    for (int k = 0; k < 4; k++) send(ms[0][k], 2'(k), 1'b0);
    end_pass(1'b0, '0, '0, 1'b0);
`ifdef KMEANS_CONVERGE_EN
    chk("conv_same", 96'(cv4), 96'd1);
`else
    chk("conv_off", 96'(cv4), 96'd0);
`endif

    begin_pass(1'b0, '0, '0);
    px = ms[0][0];
    px[23:16] = (px[23:16] == 8'd255) ? 8'd254 : px[23:16] + 8'd1;
    send(px, 2'd0, 1'b0);
    end_pass(1'b0, '0, '0, 1'b0);
    chk("conv_changed", 96'(cv4), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kmeans_centroid_update.md
Name: kmeans_centroid_update

Overview:
- Mean-update half of the K-means loop: accumulates the pixels assigned to each cluster during a pass, then divides per-channel sums by counts to produce new RGB means.
- Holds the current means and drives them as a flat vector to the pixel-to-mean distance units.
- Sits downstream of the argmin/assignment stage.

Parameters:
- K, 4, number of clusters (2..16).
- CNT_W, 20, per-cluster pixel-count width; per-channel sum width is 8+CNT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mean_load  in  1  write load_mean into means[load_idx]; honoured in IDLE only.
- load_idx  in  clog2(K)  cluster index for mean_load.
- load_mean  in  24  initial mean {R,G,B}.
- start  in  1  pulse; clears accumulators and begins a pass.
- pix_valid  in  1  pixel/assignment valid.
- pix_ready  out  1  block accepts a pixel.
- pixel  in  24  {R,G,B}, 8 bits each.
- cluster_idx  in  clog2(K)  assigned cluster.
- frame_end  in  1  pulse; last pixel of pass has been offered.
- means_flat  out  24*K  committed means; cluster k at [24k+23:24k].
- busy  out  1  state != IDLE.
- update_done  out  1  one-cycle pulse when new means are committed.
- converged  out  1  see Optional Feature.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE; means, sums, counts and shadow means all 0; pix_ready=0, busy=0, update_done=0, converged=0. Asserting rst mid-pass aborts the pass immediately, with no commit.
- States: IDLE -> ACCUM on start. ACCUM -> DIVIDE on frame_end. DIVIDE -> COMMIT after the last cluster. COMMIT -> IDLE.
- IDLE:
  - mean_load writes means[load_idx]; means_flat updates the next cycle.
  - start has priority over a coincident mean_load, which is dropped.
- ACCUM:
  - pix_ready=1.
  - A transfer occurs on pix_valid&&pix_ready: sum_c[idx] += channel, count[idx] += 1.
  - cluster_idx >= K: pixel consumed and discarded.
  - count[idx] at all-ones: pixel discarded; no wrap, no sum change.
  - A pixel coincident with frame_end is included.
  - pix_ready deasserts the cycle after frame_end.
- start outside IDLE is ignored. mean_load outside IDLE is ignored.
- DIVIDE: clusters are processed 0..K-1, channels R, G, B in order.
  - count==0: the cluster's shadow mean is copied from its current mean; costs 1 cycle per cluster.
  - Otherwise each channel is one divider run: floor(sum/count), quotient 8 bits (guaranteed since sum <= 255*count), exactly 9 cycles (1 load + 8 restoring iterations). Non-empty cluster costs 27 cycles.
  - Results go to shadow registers; means_flat is unchanged during DIVIDE.
- COMMIT: shadow means are copied to means in one cycle; update_done pulses the same cycle means_flat changes.
- Latency: frame_end to update_done = 1 + sum over clusters (27 or 1) + 1 cycles. Example: K=4, all non-empty = 110 cycles.
- Sums and counts persist after COMMIT until the next start.

Optional Feature:
- Macro: KMEANS_CONVERGE_EN.
- Defined: in COMMIT, converged is set if every shadow mean equals its current mean. It holds until the next start or rst and is valid from the update_done cycle.
- Undefined: converged is tied 0; no comparator logic.

Decomposition:
- Shared package kmeans_pkg:
  - PIX_W=24, CH_W=8, K_DEFAULT=4.
  - Channel index constants R/G/B.
  - State enum {IDLE, ACCUM, DIVIDE, COMMIT}.
  - rgb_t struct.
- Sub-module kmeans_div_u8: serial restoring divider.
  - Inputs: start, dividend (8+CNT_W), divisor (CNT_W).
  - Outputs: quotient[7:0], done.
  - Fixed 9-cycle latency.
  - Instantiated once and shared across all clusters and channels.

Test Plan:
- Reset: rst high 2 cycles mid-ACCUM -> means_flat=0, pix_ready=0, busy=0, update_done never pulses.
- Basic mean: load all means 0; start; cluster 1 gets (10,20,30), (20,30,40), (30,40,51); frame_end -> means[1]=(20,30,40); update_done exactly 1+1+27+1+1+1=32 cycles after frame_end (clusters 0, 2, 3 empty).
- Empty cluster: load means[2]=(7,8,9); pass with no pixels for cluster 2 -> means[2] stays (7,8,9).
- Boundaries (K=3, CNT_W=2):
  - cluster_idx=3 -> dropped.
  - Fifth pixel to cluster 0 -> dropped, count stays 3.
  - Pixel (90,90,90) coincident with frame_end is counted.
- Control guards: start and mean_load pulsed during DIVIDE -> no effect; means_flat constant until update_done.
- KMEANS_CONVERGE_EN defined: a pass reproducing identical means -> converged=1 with update_done. A pass changing any channel by 1 -> converged=0. Macro undefined -> converged=0 always.
